box_fifo: RTL and testbench

BOX_FIFO -- requirements
Module: box_fifo

---
 rtl/box_fifo.sv | 119 +++++++++++
 tb/tb_box_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/box_fifo.sv
// Single-clock FIFO with first-word-fall-through head, sticky overflow flag,
// selectable full-push policy and a registered random-access dump port.
module box_fifo #(
    parameter int DW        = 8,
    parameter int LGFLEN    = 5,
    parameter int OVERWRITE = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr,
    input  logic [DW-1:0]     i_data,
    input  logic              i_rd,
    output logic [DW-1:0]     o_data,
    output logic              o_empty_n,
    output logic              o_full,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_overflow,
    input  logic              i_clr_ovf,
    input  logic [LGFLEN-1:0] i_dmp_pos,
    output logic [DW-1:0]     o_dmp_data,
    output logic              o_dmp_valid
);

    localparam int              D         = 1 << LGFLEN;
    localparam logic [LGFLEN:0] FILL_MAX  = (LGFLEN+1)'(D);
    localparam logic [LGFLEN:0] FILL_ZERO = {(LGFLEN+1){1'b0}};
    localparam logic [LGFLEN:0] FILL_ONE  = (LGFLEN+1)'(1);
    localparam logic [LGFLEN-1:0] PTR_ZERO = {LGFLEN{1'b0}};
    localparam logic [LGFLEN-1:0] PTR_ONE  = LGFLEN'(1);
    localparam logic            OVR_EN    = (OVERWRITE != 0);

    logic [DW-1:0]     r_mem [D];
    logic [LGFLEN-1:0] r_wp;
    logic [LGFLEN-1:0] r_rp;
    logic [LGFLEN:0]   r_fill;
    logic              r_overflow;
    logic [DW-1:0]     r_dmp_data;
    logic              r_dmp_valid;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf_evt;
    logic              w_rp_adv;
    logic [LGFLEN:0]   w_fill_nxt;
    logic              w_dmp_hit;
    logic [LGFLEN-1:0] w_dmp_addr;

    // Accept/advance decisions and next fill, all from pre-edge state.
    always_comb begin
        w_full     = (r_fill == FILL_MAX);
        w_empty    = (r_fill == FILL_ZERO);
        w_pop      = i_rd && !w_empty;
        // Only a lone push into a full FIFO is an overflow; push+pop at full is a clean swap.
        w_ovf_evt  = i_wr && w_full && !i_rd;
        w_push     = i_wr && (!w_full || i_rd || OVR_EN);
        w_rp_adv   = w_pop || (w_ovf_evt && OVR_EN);
        w_dmp_hit  = ({1'b0, i_dmp_pos} < r_fill);
        w_dmp_addr = r_rp + i_dmp_pos;
        if (w_push && !w_pop && !w_ovf_evt) begin
            w_fill_nxt = r_fill + FILL_ONE;
        end else if (w_pop && !w_push) begin
            w_fill_nxt = r_fill - FILL_ONE;
        end else begin
            w_fill_nxt = r_fill;
        end
    end

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            r_mem[r_wp] <= i_data;
        end
    end

    // Pointers, occupancy and sticky overflow (set beats clear).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp       <= PTR_ZERO;
            r_rp       <= PTR_ZERO;
            r_fill     <= FILL_ZERO;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_rp_adv) begin
                r_rp <= r_rp + PTR_ONE;
            end
            r_fill <= w_fill_nxt;
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Dump port: one-cycle look at the word i_dmp_pos entries behind the head.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dmp_data  <= {DW{1'b0}};
            r_dmp_valid <= 1'b0;
        end else begin
            r_dmp_data  <= w_dmp_hit ? r_mem[w_dmp_addr] : {DW{1'b0}};
            r_dmp_valid <= w_dmp_hit;
        end
    end

    assign o_data      = r_mem[r_rp];
    assign o_empty_n   = !w_empty;
    assign o_full      = w_full;
    assign o_fill      = r_fill;
    assign o_overflow  = r_overflow;
    assign o_dmp_data  = r_dmp_data;
    assign o_dmp_valid = r_dmp_valid;

endmodule

// File: tb/tb_box_fifo.sv
// Directed bench for box_fifo: one default-sized FIFO plus two depth-4 FIFOs
// (drop and overwrite policies) driven by shared stimulus.
module tb_box_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] din = 8'h00;
    logic [4:0] dmp_pos = 5'd0;

    logic [7:0] b_data, b_dmp;
    logic       b_ne, b_full, b_ovf, b_dv;
    logic [5:0] b_fill;

    logic [7:0] d_data, d_dmp;
    logic       d_ne, d_full, d_ovf, d_dv;
    logic [2:0] d_fill;

    logic [7:0] o_data_ow, o_dmp_ow;
    logic       o_ne, o_full_ow, o_ovf_ow, o_dv;
    logic [2:0] o_fill_ow;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    box_fifo u_big (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_data(din), .i_rd(rd),
        .o_data(b_data), .o_empty_n(b_ne), .o_full(b_full), .o_fill(b_fill),
        .o_overflow(b_ovf), .i_clr_ovf(clr), .i_dmp_pos(dmp_pos),
        .o_dmp_data(b_dmp), .o_dmp_valid(b_dv)
    );

    box_fifo #(.DW(8), .LGFLEN(2), .OVERWRITE(0)) u_drop (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_data(din), .i_rd(rd),
        .o_data(d_data), .o_empty_n(d_ne), .o_full(d_full), .o_fill(d_fill),
        .o_overflow(d_ovf), .i_clr_ovf(clr), .i_dmp_pos(dmp_pos[1:0]),
        .o_dmp_data(d_dmp), .o_dmp_valid(d_dv)
    );

    box_fifo #(.DW(8), .LGFLEN(2), .OVERWRITE(1)) u_ovw (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_data(din), .i_rd(rd),
        .o_data(o_data_ow), .o_empty_n(o_ne), .o_full(o_full_ow), .o_fill(o_fill_ow),
        .o_overflow(o_ovf_ow), .i_clr_ovf(clr), .i_dmp_pos(dmp_pos[1:0]),
        .o_dmp_data(o_dmp_ow), .o_dmp_valid(o_dv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        wr  = w;
        rd  = r;
        din = d;
        tick();
        wr  = 1'b0;
        rd  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_fill", b_fill, 32'd0);
        chk("rst_empty_n", b_ne, 32'd0);
        chk("rst_full", b_full, 32'd0);
        chk("rst_ovf", b_ovf, 32'd0);
        chk("rst_dmp_valid", b_dv, 32'd0);
        chk("rst_dmp_data", b_dmp, 32'd0);

        // Basic push/pop
        cycle(1'b1, 1'b0, 8'h41);
        cycle(1'b1, 1'b0, 8'h42);
        cycle(1'b1, 1'b0, 8'h43);
        chk("push3_fill", b_fill, 32'd3);
        chk("push3_head", b_data, 32'h41);
        chk("push3_empty_n", b_ne, 32'd1);
        cycle(1'b0, 1'b1, 8'h00);
        chk("pop_head", b_data, 32'h42);
        chk("pop_fill", b_fill, 32'd2);

        // Dump port
        do_reset();
        cycle(1'b1, 1'b0, 8'hA0);
        cycle(1'b1, 1'b0, 8'hA1);
        cycle(1'b1, 1'b0, 8'hA2);
        dmp_pos = 5'd2;
        tick();
        chk("dmp2_data", b_dmp, 32'hA2);
        chk("dmp2_valid", b_dv, 32'd1);
        dmp_pos = 5'd3;
        tick();
        chk("dmp3_data", b_dmp, 32'h00);
        chk("dmp3_valid", b_dv, 32'd0);
        chk("dmp_no_side_effect", b_fill, 32'd3);
        dmp_pos = 5'd0;

        // Full behaviour, drop vs overwrite
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h10 + 8'(i));
        chk("drop_full", d_full, 32'd1);
        chk("drop_ovf_before", d_ovf, 32'd0);
        cycle(1'b1, 1'b0, 8'h14);
        chk("drop_ovf", d_ovf, 32'd1);
        chk("drop_head", d_data, 32'h10);
        chk("drop_fill", d_fill, 32'd4);
        chk("ovw_head5", o_data_ow, 32'h11);
        cycle(1'b1, 1'b0, 8'h15);
        chk("ovw_fill", o_fill_ow, 32'd4);
        chk("ovw_head", o_data_ow, 32'h12);
        chk("ovw_ovf", o_ovf_ow, 32'd1);
        chk("drop_head6", d_data, 32'h10);
        chk("big_fill6", b_fill, 32'd6);
        dmp_pos = 5'd3;
        tick();
        chk("ovw_dmp_wrap", o_dmp_ow, 32'h15);
        chk("ovw_dmp_valid", o_dv, 32'd1);
        chk("big_dmp3", b_dmp, 32'h13);
        dmp_pos = 5'd0;

        // Clear vs set in the same cycle, then clear alone
        clr = 1'b1;
        cycle(1'b1, 1'b0, 8'h16);
        clr = 1'b0;
        chk("set_wins_drop", d_ovf, 32'd1);
        chk("set_wins_ovw", o_ovf_ow, 32'd1);
        chk("ovw_head7", o_data_ow, 32'h13);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_drop", d_ovf, 32'd0);
        chk("clr_ovw", o_ovf_ow, 32'd0);

        // Push+pop at full
        cycle(1'b1, 1'b1, 8'h20);
        chk("full_pp_fill", d_fill, 32'd4);
        chk("full_pp_ovf", d_ovf, 32'd0);
        chk("full_pp_head", d_data, 32'h11);
        chk("full_pp_ovw_head", o_data_ow, 32'h14);
        chk("full_pp_ovw_ovf", o_ovf_ow, 32'd0);

        // Push+pop at empty and mid-fill
        do_reset();
        cycle(1'b1, 1'b1, 8'h30);
        chk("empty_pp_fill", d_fill, 32'd1);
        chk("empty_pp_head", d_data, 32'h30);
        cycle(1'b1, 1'b1, 8'h31);
        chk("mid_pp_fill1", d_fill, 32'd1);
        chk("mid_pp_head1", d_data, 32'h31);
        cycle(1'b1, 1'b0, 8'h32);
        cycle(1'b1, 1'b1, 8'h33);
        chk("mid_pp_fill2", d_fill, 32'd2);
        chk("mid_pp_head2", d_data, 32'h32);

        // Pointer wrap over many operations, then pop-when-empty
        do_reset();
        cycle(1'b1, 1'b0, 8'h40);
        cycle(1'b1, 1'b0, 8'h41);
        for (int j = 0; j < 10; j++) begin
            cycle(1'b1, 1'b1, 8'h42 + 8'(j));
            chk("wrap_head", d_data, 32'h41 + j);
        end
        chk("wrap_fill", d_fill, 32'd2);
        chk("wrap_ovw_head", o_data_ow, 32'h4A);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        chk("pop_empty_fill", d_fill, 32'd0);
        chk("pop_empty_ne", d_ne, 32'd0);
        cycle(1'b1, 1'b0, 8'h66);
        chk("after_empty_head", d_data, 32'h66);
        chk("after_empty_fill", d_fill, 32'd1);

        // Reset mid-stream with a concurrent push
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h70 + 8'(i));
        chk("pre_rst_fill", b_fill, 32'd5);
        dmp_pos = 5'd1;
        rst = 1'b1;
        cycle(1'b1, 1'b0, 8'h99);
        rst = 1'b0;
        chk("midrst_fill", b_fill, 32'd0);
        chk("midrst_ne", b_ne, 32'd0);
        chk("midrst_dv", b_dv, 32'd0);
        chk("midrst_ovf", d_ovf, 32'd0);
        dmp_pos = 5'd0;
        cycle(1'b1, 1'b0, 8'h77);
        chk("post_rst_head", b_data, 32'h77);
        chk("post_rst_fill", b_fill, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
